// File: rtl/request_conditioner_pkg.sv
// Shared constants, FSM encoding and helpers for the pushbutton request conditioner.
package request_conditioner_pkg;

  localparam int NUM_REQ                 = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // 2'd3 is unused and recovers to ST_IDLE
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SERVING = 2'd2;

  function automatic logic req_active(input logic [1:0] st);
    return (st == ST_PENDING) || (st == ST_SERVING);
  endfunction

endpackage

// File: rtl/request_conditioner_if.sv
// Button/grant/request bundle between the arbiter front end and its environment.
interface request_conditioner_if;
  import request_conditioner_pkg::*;

  req_vec_t btn_in;
  req_vec_t grant_in;
  req_vec_t request_queue;
  req_vec_t press_pulse;
  req_vec_t serviced_pulse;

  modport master (
    output btn_in,
    output grant_in,
    input  request_queue,
    input  press_pulse,
    input  serviced_pulse
  );

  modport slave (
    input  btn_in,
    input  grant_in,
    output request_queue,
    output press_pulse,
    output serviced_pulse
  );

endinterface

// File: rtl/request_conditioner_debounce_channel.sv
// One button channel: 2-FF synchroniser, stable-level debouncer and rising-edge press detect.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the asynchronous button level into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive disagreeing edges
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      stable_d_r <= stable_r;
      if (sync2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_r <= ~stable_r;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign press = stable_r & ~stable_d_r;

endmodule

// File: rtl/request_conditioner.sv
// Turns four raw pushbuttons into sticky arbiter requests held until each grant completes.
module request_conditioner
  import request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input logic                   clk,
  input logic                   reset,
  request_conditioner_if.slave  bus
);

  req_vec_t                  press_s;
  logic [NUM_REQ-1:0][1:0]   state_r;
  logic [NUM_REQ-1:0][1:0]   state_nxt_s;
  req_vec_t                  rearm_r;
  req_vec_t                  rearm_nxt_s;
  req_vec_t                  serviced_nxt_s;
  req_vec_t                  request_nxt_s;
  req_vec_t                  request_r;
  req_vec_t                  press_pulse_r;
  req_vec_t                  serviced_r;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (bus.btn_in[g]),
      .press (press_s[g])
    );
  end

  // Per-channel request FSM; a press while serving is remembered in rearm
  always_comb begin
    state_nxt_s    = state_r;
    rearm_nxt_s    = rearm_r;
    serviced_nxt_s = {NUM_REQ{1'b0}};
    request_nxt_s  = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      case (state_r[i])
        ST_IDLE: begin
          if (press_s[i]) begin
            state_nxt_s[i] = ST_PENDING;
          end else begin
            state_nxt_s[i] = ST_IDLE;
          end
        end
        ST_PENDING: begin
          if (bus.grant_in[i]) begin
            state_nxt_s[i] = ST_SERVING;
          end else begin
            state_nxt_s[i] = ST_PENDING;
          end
        end
        ST_SERVING: begin
          if (!bus.grant_in[i]) begin
            serviced_nxt_s[i] = 1'b1;
            rearm_nxt_s[i]    = 1'b0;
            if (rearm_r[i] || press_s[i]) begin
              state_nxt_s[i] = ST_PENDING;
            end else begin
              state_nxt_s[i] = ST_IDLE;
            end
          end else if (press_s[i]) begin
            rearm_nxt_s[i] = 1'b1;
          end else begin
            rearm_nxt_s[i] = rearm_r[i];
          end
        end
        default: begin
          state_nxt_s[i] = ST_IDLE;
          rearm_nxt_s[i] = 1'b0;
        end
      endcase
      request_nxt_s[i] = req_active(state_nxt_s[i]);
    end
  end

  // State and output registers; request mirrors the registered state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= {NUM_REQ{ST_IDLE}};
      rearm_r       <= {NUM_REQ{1'b0}};
      request_r     <= {NUM_REQ{1'b0}};
      press_pulse_r <= {NUM_REQ{1'b0}};
      serviced_r    <= {NUM_REQ{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      rearm_r       <= rearm_nxt_s;
      request_r     <= request_nxt_s;
      press_pulse_r <= press_s;
      serviced_r    <= serviced_nxt_s;
    end
  end

  assign bus.request_queue  = request_r;
  assign bus.press_pulse    = press_pulse_r;
  assign bus.serviced_pulse = serviced_r;

endmodule
